// File: rtl/serial_pkg.sv
// Shared serial-line definitions: receiver FSM states and line-level constants
// common to the transmitter and receiver sides.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Parallel word output of the serial receiver: valid/ready handshake plus data.
// A word moves on any rising edge where data_valid && data_ready; the producer
// holds data_out stable while data_valid is high and data_ready is low.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out register: each enabled edge shifts din in at the MSB,
// so after W shifts the first bit received sits in bit 0.
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  generate
    if (W == 1) begin : g_single
      assign q_d = din;
    end else begin : g_multi
      assign q_d = {din, q_q[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (shift_en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even
// parity, stop bit; good words land in a one-entry holding register.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  serial_frame_rx_if.master   rx_if,
  input  logic                err_clr,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun,
  output logic                busy,
  output rx_state_t           state_dbg
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t         state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              par_q;
  logic              busy_q;
  logic [DATA_W-1:0] shift_q;

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;

  logic last_bit;
  logic in_stop;
  logic stop_ok;
  logic parity_ok;
  logic good;
  logic consume;
  logic load;

  assign last_bit = (bit_cnt_q == CNT_W'(DATA_W - 1));

  // par_q accumulates data bits and the parity bit; even parity leaves it 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (serial_in == START_BIT) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        DATA: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          par_q     <= par_q ^ serial_in;
          if (last_bit) begin
            state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_q   <= par_q ^ serial_in;
          state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sipo_shift #(
    .W (DATA_W)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (state_q == DATA),
    .din      (serial_in),
    .q        (shift_q)
  );

  assign in_stop   = (state_q == STOP);
  assign stop_ok   = (serial_in == STOP_BIT);
  assign parity_ok = (PARITY_EN == 0) || !par_q;
  assign good      = in_stop && stop_ok && parity_ok;
  assign consume   = valid_q && rx_if.data_ready;
  assign load      = good && (!valid_q || rx_if.data_ready);

  // Error flags: a new event in the same cycle as err_clr leaves the flag set.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (consume) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end
    frame_err_d  = (in_stop && !stop_ok)   || (frame_err_q  && !err_clr);
    parity_err_d = (in_stop && !parity_ok) || (parity_err_q && !err_clr);
    overrun_d    = (good && valid_q && !rx_if.data_ready) || (overrun_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign frame_err        = frame_err_q;
  assign parity_err       = parity_err_q;
  assign overrun          = overrun_q;
  assign busy             = busy_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (DATA_W = 8, even parity enabled):
// directed frames, error and handshake corner cases, then random good frames.
module tb_serial_frame_rx;
  import serial_pkg::*;

  localparam int W = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  logic      serial_in = 1'b0;
  logic      err_clr = 1'b0;
  logic      frame_err;
  logic      parity_err;
  logic      overrun;
  logic      busy;
  rx_state_t state_dbg;

  serial_frame_rx_if #(.DATA_W(W)) rx_if ();

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rnd_word;

  serial_frame_rx #(
    .DATA_W    (W),
    .PARITY_EN (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .rx_if      (rx_if),
    .err_clr    (err_clr),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      serial_in = LINE_IDLE;
    end
  endtask

  // Returns while the stop bit is on the line, before the edge that samples it.
  task automatic send_frame(input logic [W-1:0] w, input bit bad_par, input bit bad_stop,
                            input bit clr_at_stop, input bit rdy_at_stop);
    @(negedge clk);
    serial_in = START_BIT;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      serial_in = w[i];
      if (i == 0) begin
        check_val("busy_in_frame", 32'(busy), 32'd1);
        check_val("state_in_frame", 32'(state_dbg), 32'(DATA));
      end
    end
    @(negedge clk);
    serial_in = (^w) ^ bad_par;
    @(negedge clk);
    serial_in = bad_stop ? ~STOP_BIT : STOP_BIT;
    if (clr_at_stop) err_clr = 1'b1;
    if (rdy_at_stop) rx_if.data_ready = 1'b1;
  endtask

  task automatic end_frame();
    @(negedge clk);
    serial_in = LINE_IDLE;
    err_clr   = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected word.
  always @(negedge clk) begin
    #1;
    if (rst && rx_if.data_valid && rx_if.data_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        check_val("word", 32'(rx_if.data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rx_if.data_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(rx_if.data_valid), 32'd0);
    check_val("rst_data", 32'(rx_if.data_out), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
    check_val("rst_parity_err", 32'(parity_err), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;

    // Single good frame, valid for exactly one cycle
    rx_if.data_ready = 1'b1;
    idle(2);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame();
    check_val("single_valid", 32'(rx_if.data_valid), 32'd1);
    check_val("single_busy", 32'(busy), 32'd0);
    check_val("single_frame_err", 32'(frame_err), 32'd0);
    check_val("single_parity_err", 32'(parity_err), 32'd0);
    check_val("single_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    check_val("single_valid_drop", 32'(rx_if.data_valid), 32'd0);

    // Parity error, then clear
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    end_frame();
    check_val("par_parity_err", 32'(parity_err), 32'd1);
    check_val("par_frame_err", 32'(frame_err), 32'd0);
    check_val("par_valid", 32'(rx_if.data_valid), 32'd0);
    pulse_clr();
    check_val("par_cleared", 32'(parity_err), 32'd0);

    // Frame error; a second one coinciding with err_clr must leave the flag set
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    end_frame();
    check_val("frm_frame_err", 32'(frame_err), 32'd1);
    check_val("frm_parity_err", 32'(parity_err), 32'd0);
    check_val("frm_valid", 32'(rx_if.data_valid), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    end_frame();
    check_val("frm_set_wins", 32'(frame_err), 32'd1);
    pulse_clr();
    check_val("frm_cleared", 32'(frame_err), 32'd0);

    // Overrun: second back-to-back frame dropped while holding register full
    rx_if.data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame();
    check_val("ovr_data_kept", 32'(rx_if.data_out), 32'h11);
    check_val("ovr_valid", 32'(rx_if.data_valid), 32'd1);
    check_val("ovr_overrun", 32'(overrun), 32'd1);
    check_val("ovr_parity_err", 32'(parity_err), 32'd0);
    rx_if.data_ready = 1'b1;
    @(negedge clk);
    check_val("ovr_consumed", 32'(rx_if.data_valid), 32'd0);
    pulse_clr();
    check_val("ovr_cleared", 32'(overrun), 32'd0);

    // Load on consume: ready rises in the stop-bit cycle of the second frame
    rx_if.data_ready = 1'b0;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    end_frame();
    check_val("loc_valid", 32'(rx_if.data_valid), 32'd1);
    check_val("loc_data", 32'(rx_if.data_out), 32'h22);
    check_val("loc_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    check_val("loc_valid_drop", 32'(rx_if.data_valid), 32'd0);

    // Reset during data bit 4, then a clean frame
    @(negedge clk);
    serial_in = START_BIT;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      serial_in = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst       = 1'b1;
    serial_in = LINE_IDLE;
    idle(2);
    check_val("post_rst_state", 32'(state_dbg), 32'(IDLE));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    end_frame();
    check_val("post_rst_valid", 32'(rx_if.data_valid), 32'd1);
    check_val("post_rst_frame_err", 32'(frame_err), 32'd0);
    check_val("post_rst_parity_err", 32'(parity_err), 32'd0);
    check_val("post_rst_overrun", 32'(overrun), 32'd0);

    // Random good frames, back-to-back or with short gaps
    for (int k = 0; k < 8; k++) begin
      rnd_word = W'($urandom_range(0, 255));
      exp_q.push_back(rnd_word);
      send_frame(rnd_word, 1'b0, 1'b0, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(4);
    check_val("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    check_val("final_errors_clear", 32'({frame_err, parity_err, overrun}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Downstream consumer of the single-bit serial shift-register line. It watches `serial_in` one bit per clock, detects a start bit, and shifts in a fixed-width data word. It then checks an optional even-parity bit and the stop bit, and presents the word on a parallel valid/ready interface through a one-entry holding register, with sticky error and overrun status.

## Interface
- `DATA_W`, default 8: payload bits per frame, 1..32.
- `PARITY_EN`, default 1: 1 = even-parity bit follows the data; 0 = no parity bit.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `serial_in` input 1: serial line; idle level 0.
- `data_out` output DATA_W: received word, LSB = first data bit received.
- `data_valid` output 1: holding register holds an unconsumed word.
- `data_ready` input 1: consumer accepts the word when `data_valid && data_ready`.
- `err_clr` input 1: clears all sticky status flags.
- `frame_err` output 1: sticky; a stop bit was sampled as 1.
- `parity_err` output 1: sticky; parity mismatch.
- `overrun` output 1: sticky; a good frame was dropped because the holding register was full.
- `busy` output 1: FSM is not in IDLE.

## Operation
- Frame on the line, one bit per clock: start bit = 1, DATA_W data bits LSB first, parity bit if PARITY_EN, stop bit = 0.
- Parity is even: the XOR of the data bits and the parity bit must be 0.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: `serial_in == 1` moves to DATA and clears `bit_cnt`. `serial_in == 0` stays in IDLE.
  - DATA: shifts `serial_in` into the shift register and increments `bit_cnt`. After DATA_W bits, moves to PARITY if PARITY_EN, otherwise to STOP.
  - PARITY: captures the parity bit, then moves to STOP.
  - STOP: samples the stop bit, then always returns to IDLE.
- Frame is good when stop bit = 0 and parity is OK (parity is always OK when PARITY_EN = 0).
- Good frame:
  - Loads `data_out` and sets `data_valid`, if the holding register is empty or is being consumed in the same cycle.
  - Otherwise the frame is dropped: `overrun` sets and `data_out` keeps the old word.
- Bad frame: never loads `data_out`. Sets `frame_err` and/or `parity_err`.
- Handshake:
  - `data_valid` clears on `data_valid && data_ready`, unless a good frame loads in the same cycle, in which case `data_valid` stays 1 and holds the new word.
  - `data_out` is stable while `data_valid && !data_ready`.
- Sticky flags:
  - `err_clr` clears all three flags.
  - If `err_clr` coincides with a new error event, the flag ends up set (set wins).
- Reset values: `data_out` = 0, `data_valid` = 0, all error flags = 0, `busy` = 0, state = IDLE, `bit_cnt` = 0.
- Reset mid-frame abandons the partial frame; reception resumes from IDLE after `rst` deasserts.

## Timing
- Cycle 0 is the edge sampling the start bit. Data bits are sampled at cycles 1..DATA_W.
- Parity is sampled at cycle DATA_W+1 when PARITY_EN. The stop bit is sampled at DATA_W+1+PARITY_EN.
- `data_valid` and status flags are registered; they become visible the cycle after the stop-bit edge.
- Back-to-back frames are supported: a start bit may arrive the cycle immediately after the stop bit.
- A 1 on the line in IDLE always starts a frame; there is no glitch filtering.
- `busy` is high from the cycle after the start-bit edge through the stop-bit cycle.
- `data_ready` has no combinational path to any output.

## Structure
- Shared package `serial_pkg`:
  - State enum `rx_state_t` (IDLE, DATA, PARITY, STOP).
  - Constants `LINE_IDLE` = 0, `START_BIT` = 1, `STOP_BIT` = 0.
  - These are shared with the upstream transmitter side.
- One sub-module, `sipo_shift`: DATA_W-bit serial-in/parallel-out register with shift enable and async active-low reset.
- The FSM, counter, parity accumulator, holding register and status flags live in the top module.

## Test plan
All scenarios use DATA_W = 8 and PARITY_EN = 1.
- **Single frame:** drive 1, then bits 1,0,1,0,0,1,0,1, parity 0, stop 0, with `data_ready` = 1 -> `data_out` = 8'hA5 and `data_valid` = 1 for one cycle at cycle 11; no error flags set.
- **Parity error:** send 0xA5 with parity bit = 1 -> `parity_err` = 1, `data_valid` stays 0. Pulse `err_clr` -> `parity_err` = 0.
- **Frame error:** send 0x3C with correct parity and stop bit = 1 -> `frame_err` = 1, no word delivered.
- **Overrun:** `data_ready` = 0; send 0x11 then back-to-back 0x22 -> `data_out` stays 8'h11 and `overrun` = 1. Raise `data_ready` -> 0x11 consumed, `data_valid` = 0.
- **Load on consume:** `data_ready` rises exactly on the cycle the second frame completes -> 0x11 is consumed, `data_out` = 0x22, `data_valid` stays 1, `overrun` = 0.
- **Reset mid-frame:** assert `rst` low during data bit 4, release, then send 0x5A -> `data_out` = 8'h5A, no stale bits, no error flags.
